branch_fb_queue: RTL and testbench
==================================

Name: branch_fb_queue

Overview:
- In-order tracking queue between fetch (where perceptron_predictor makes predictions) and execute (where branches resolve).
- Records {pc, prediction} for every predicted branch at allocation.
- Pops the oldest entry on resolution and drives the predictor's feedback interface (i_fb_valid/pc/prediction/outcome) one cycle later.
- Squashes wrong-path entries on a misprediction and keeps saturating branch and mispredict counters for performance measurement.

Parameters:
- DEPTH, 8, number of outstanding predicted branches; power of two, >=2.
- ADDR_WIDTH, `ADDR_WIDTH (32), PC width.
- CNT_WIDTH, 32, width of each performance counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_alloc_valid  in  1  fetch has predicted a branch this cycle.
- i_alloc_pc  in  ADDR_WIDTH  branch PC.
- i_alloc_prediction  in  BranchOutcome  prediction made by the predictor.
- o_alloc_ready  out  1  queue not full; allocation accepted only when high.
- i_res_valid  in  1  execute resolves the oldest outstanding branch.
- i_res_outcome  in  BranchOutcome  actual outcome.
- i_flush  in  1  external pipeline flush (exception/redirect); clears all entries.
- o_fb_valid  out  1  feedback pulse to predictor.
- o_fb_pc  out  ADDR_WIDTH  PC of the resolved branch.
- o_fb_prediction  out  BranchOutcome  stored prediction.
- o_fb_outcome  out  BranchOutcome  actual outcome.
- o_mispredict  out  1  pulse coincident with o_fb_valid when prediction != outcome.
- o_underflow  out  1  pulse: resolve arrived with the queue empty.
- o_branch_count  out  CNT_WIDTH  resolved branches, saturating.
- o_mispredict_count  out  CNT_WIDTH  mispredicted branches, saturating.

Behaviour:
- Storage: circular buffer of DEPTH entries {pc, prediction}.
  - Head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Separate occupancy counter, log2(DEPTH)+1 bits.
- Reset (async): pointers, occupancy and counters go to 0. All outputs go to 0; o_fb_prediction and o_fb_outcome go to NOT_TAKEN; o_alloc_ready goes to 1. Entry contents are don't-care.
- o_alloc_ready = (occupancy != DEPTH), decoded from registered state only.
  - When full, a same-cycle resolve does NOT enable a same-cycle allocation.
- Allocation: accepted when i_alloc_valid && o_alloc_ready. Writes the entry at tail, tail+1.
  - i_alloc_valid while not ready is dropped silently; upstream must stall.
- Resolve with occupancy > 0:
  - Next cycle: o_fb_valid=1, o_fb_pc/o_fb_prediction taken from the head entry, o_fb_outcome=i_res_outcome, o_mispredict=(prediction != outcome).
  - head+1; o_branch_count+1; o_mispredict_count+1 if mispredicted.
  - Latency resolve->feedback: exactly 1 cycle. Feedback outputs are registered.
  - o_fb_valid and o_mispredict are single-cycle pulses. o_fb_pc/prediction/outcome hold their last value when o_fb_valid=0.
- Resolve with occupancy == 0: no feedback, no counter change; o_underflow pulses 1 cycle later.
- Mispredict squash: a mispredicted resolve discards all younger entries.
  - tail <= head+1, occupancy <= 0.
  - A same-cycle allocation is also discarded, since it is wrong-path.
- i_flush: clears the queue (tail <= head after any same-cycle pop; occupancy <= 0) and discards any same-cycle allocation.
  - A same-cycle valid resolve still pops, still emits feedback next cycle and still updates counters.
- Simultaneous correctly-predicted resolve and accepted allocation: occupancy unchanged; both pointers advance.
- Counters saturate at all-ones; no wrap.
- Mid-operation reset: everything returns to reset values immediately. Any feedback pulse in flight is lost.

Decomposition:
- mips_core_pkg already supplies BranchOutcome (TAKEN/NOT_TAKEN).
- Add to the package:
  - typedef branch_fb_entry_t {pc, prediction};
  - localparam BRANCH_FB_DEPTH = 8, shared with the fetch stall logic.
- One natural sub-module: sat_counter (parameterised width, inc enable, async reset), instantiated twice for the performance counters.

Test Plan:
- Reset, then allocate 3 branches (pc 0x100 T, 0x104 NT, 0x108 T), then resolve T, NT, T on consecutive cycles -> three o_fb_valid pulses, each 1 cycle after its resolve; pcs 0x100, 0x104, 0x108 in order; o_mispredict=0; o_branch_count=3; o_mispredict_count=0.
- Allocate 8 entries -> o_alloc_ready=0. A 9th alloc is dropped. Resolve+alloc in the same cycle while full -> alloc ignored; occupancy goes to 7, o_alloc_ready=1 next cycle.
- Allocate 4 entries (0x200 predicted T), resolve NT -> o_mispredict=1 with o_fb_pc=0x200; queue empty next cycle. A following resolve gives o_underflow=1 and no o_fb_valid.
- i_flush together with a valid resolve and a valid alloc -> feedback emitted for the head entry; queue empty afterwards; allocated pc absent (next resolve underflows).
- Wrap-around: 20 alloc/resolve pairs at DEPTH=8 -> feedback pc order matches allocation order across the pointer wrap.
- Force counters near saturation (CNT_WIDTH=4 build), apply 20 mispredicts -> both counters hold 15. Assert rst_n mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/branch_fb_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_fb_queue_pkg
// Description : Shared types for the branch feedback queue. Provides the
//               branch outcome encoding, the queue entry layout and the
//               queue depth used by the fetch stall logic.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package branch_fb_queue_pkg;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  localparam int BRANCH_FB_ADDR_WIDTH = `ADDR_WIDTH;

  // Outstanding-branch capacity; fetch stalls once this many are in flight.
  localparam int BRANCH_FB_DEPTH = 8;

  typedef struct packed {
    logic [BRANCH_FB_ADDR_WIDTH-1:0] pc;
    BranchOutcome                    prediction;
  } branch_fb_entry_t;

endpackage

`default_nettype wire

// File: rtl/branch_fb_queue_sat.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up counter that stops at all-ones instead of wrapping.
// Ports       : clk, rst_n (async, active-low)
//               i_inc    - increment request for this cycle
//               o_count  - current count
// Revision    : 1.0 - initial release
// ============================================================================

module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/branch_fb_queue.sv
`default_nettype none
// ============================================================================
// Module      : branch_fb_queue
// Description : In-order queue of predicted branches between fetch and
//               execute. Each resolution pops the oldest entry and drives a
//               registered feedback pulse to the predictor one cycle later.
//               Mispredictions and flushes squash younger entries. Saturating
//               counters track resolved and mispredicted branches.
// Ports       : clk, rst_n (async, active-low)
//               i_alloc_*  - new predicted branch from fetch
//               o_alloc_ready - queue has space
//               i_res_*    - resolution of the oldest branch
//               i_flush    - drop all outstanding entries
//               o_fb_*     - feedback to predictor (1 cycle after resolve)
//               o_mispredict, o_underflow - single-cycle status pulses
//               o_branch_count, o_mispredict_count - saturating counters
// Revision    : 1.0 - initial release
// ============================================================================

module branch_fb_queue
  import branch_fb_queue_pkg::*;
#(
  parameter int DEPTH      = BRANCH_FB_DEPTH,
  parameter int ADDR_WIDTH = BRANCH_FB_ADDR_WIDTH,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_alloc_valid,
  input  logic [ADDR_WIDTH-1:0] i_alloc_pc,
  input  BranchOutcome          i_alloc_prediction,
  output logic                  o_alloc_ready,
  input  logic                  i_res_valid,
  input  BranchOutcome          i_res_outcome,
  input  logic                  i_flush,
  output logic                  o_fb_valid,
  output logic [ADDR_WIDTH-1:0] o_fb_pc,
  output BranchOutcome          o_fb_prediction,
  output BranchOutcome          o_fb_outcome,
  output logic                  o_mispredict,
  output logic                  o_underflow,
  output logic [CNT_WIDTH-1:0]  o_branch_count,
  output logic [CNT_WIDTH-1:0]  o_mispredict_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] c_full  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] c_empty = '0;

  // Entry layout sized by this instance's PC width.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    BranchOutcome          prediction;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_occ;

  logic                  r_fb_valid;
  logic [ADDR_WIDTH-1:0] r_fb_pc;
  BranchOutcome          r_fb_prediction;
  BranchOutcome          r_fb_outcome;
  logic                  r_mispredict;
  logic                  r_underflow;

  logic             w_alloc_ready;
  logic             w_alloc_fire;
  logic             w_res_fire;
  logic             w_res_empty;
  logic             w_mispred;
  logic             w_squash;
  entry_t           w_head_entry;
  logic [PTR_W-1:0] w_head_next;
  logic [PTR_W-1:0] w_tail_next;
  logic [PTR_W:0]   w_occ_next;

  // Readiness comes from registered occupancy only, so a pop in the same
  // cycle never frees a slot for an allocation in that cycle.
  assign w_alloc_ready = (r_occ != c_full);
  assign w_alloc_fire  = i_alloc_valid && w_alloc_ready;
  assign w_res_fire    = i_res_valid && (r_occ != c_empty);
  assign w_res_empty   = i_res_valid && (r_occ == c_empty);
  assign w_head_entry  = r_mem[r_head];
  assign w_mispred     = w_res_fire && (w_head_entry.prediction != i_res_outcome);

  // A mispredict or flush makes every younger entry (including any
  // allocation arriving this cycle) wrong-path.
  assign w_squash      = w_mispred || i_flush;
  assign w_head_next   = w_res_fire ? (r_head + PTR_W'(1)) : r_head;

  always_comb begin
    w_tail_next = r_tail;
    w_occ_next  = r_occ;
    if (w_squash) begin
      // Empty queue: tail meets the post-pop head.
      w_tail_next = w_head_next;
      w_occ_next  = '0;
    end else begin
      if (w_alloc_fire) begin
        w_tail_next = r_tail + PTR_W'(1);
      end
      case ({w_alloc_fire, w_res_fire})
        2'b10:   w_occ_next = r_occ + (PTR_W+1)'(1);
        2'b01:   w_occ_next = r_occ - (PTR_W+1)'(1);
        default: w_occ_next = r_occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      r_head <= w_head_next;
      r_tail <= w_tail_next;
      r_occ  <= w_occ_next;
    end
  end

  // Entry storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (w_alloc_fire && !w_squash) begin
      r_mem[r_tail] <= '{pc: i_alloc_pc, prediction: i_alloc_prediction};
    end
  end

  // Feedback payload holds its last value between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fb_valid      <= 1'b0;
      r_fb_pc         <= '0;
      r_fb_prediction <= NOT_TAKEN;
      r_fb_outcome    <= NOT_TAKEN;
      r_mispredict    <= 1'b0;
      r_underflow     <= 1'b0;
    end else begin
      r_fb_valid   <= w_res_fire;
      r_mispredict <= w_mispred;
      r_underflow  <= w_res_empty;
      if (w_res_fire) begin
        r_fb_pc         <= w_head_entry.pc;
        r_fb_prediction <= w_head_entry.prediction;
        r_fb_outcome    <= i_res_outcome;
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_branch_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_res_fire),
    .o_count (o_branch_count)
  );

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_mispredict_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_mispred),
    .o_count (o_mispredict_count)
  );

  assign o_alloc_ready   = w_alloc_ready;
  assign o_fb_valid      = r_fb_valid;
  assign o_fb_pc         = r_fb_pc;
  assign o_fb_prediction = r_fb_prediction;
  assign o_fb_outcome    = r_fb_outcome;
  assign o_mispredict    = r_mispredict;
  assign o_underflow     = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_branch_fb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_fb_queue
// Description : Scoreboard bench for branch_fb_queue. A queue-based model
//               predicts each feedback/underflow event; a monitor compares
//               DUT pulses against the expected events.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_branch_fb_queue;
  import branch_fb_queue_pkg::*;

  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;
  localparam int QD   = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_alloc_valid = 1'b0;
  logic [31:0]  i_alloc_pc = '0;
  BranchOutcome i_alloc_prediction = NOT_TAKEN;
  logic         o_alloc_ready;
  logic         i_res_valid = 1'b0;
  BranchOutcome i_res_outcome = NOT_TAKEN;
  logic         i_flush = 1'b0;
  logic         o_fb_valid;
  logic [31:0]  o_fb_pc;
  BranchOutcome o_fb_prediction;
  BranchOutcome o_fb_outcome;
  logic         o_mispredict;
  logic         o_underflow;
  logic [CW-1:0] o_branch_count;
  logic [CW-1:0] o_mispredict_count;

  branch_fb_queue #(.DEPTH(QD), .ADDR_WIDTH(32), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_alloc_valid(i_alloc_valid), .i_alloc_pc(i_alloc_pc),
    .i_alloc_prediction(i_alloc_prediction), .o_alloc_ready(o_alloc_ready),
    .i_res_valid(i_res_valid), .i_res_outcome(i_res_outcome), .i_flush(i_flush),
    .o_fb_valid(o_fb_valid), .o_fb_pc(o_fb_pc), .o_fb_prediction(o_fb_prediction),
    .o_fb_outcome(o_fb_outcome), .o_mispredict(o_mispredict), .o_underflow(o_underflow),
    .o_branch_count(o_branch_count), .o_mispredict_count(o_mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  pc;
    BranchOutcome pred;
  } ent_t;

  typedef struct {
    int           cyc;
    bit           uf;
    logic [31:0]  pc;
    BranchOutcome pred;
    BranchOutcome outc;
    bit           mis;
    int           bc;
    int           mc;
  } ev_t;

  ent_t model_q[$];
  ev_t  exp_q[$];
  int   bcnt = 0, mcnt = 0;
  int   cyc_cnt = 0;
  int   n_checks = 0, n_errors = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the model computes what the DUT must show next cycle.
  task automatic step(input bit av, input logic [31:0] apc, input BranchOutcome ap,
                      input bit rv, input BranchOutcome ro, input bit fl);
    bit   ready, mis;
    ent_t e;
    ev_t  ev;
    @(negedge clk);
    ready = (model_q.size() != QD);
    chk("alloc_ready", {63'd0, o_alloc_ready}, {63'd0, ready});
    i_alloc_valid = av; i_alloc_pc = apc; i_alloc_prediction = ap;
    i_res_valid = rv; i_res_outcome = ro; i_flush = fl;
    mis = 1'b0;
    if (rv) begin
      ev = '{cyc: cyc_cnt + 1, uf: 1'b1, pc: '0, pred: NOT_TAKEN, outc: NOT_TAKEN,
             mis: 1'b0, bc: 0, mc: 0};
      if (model_q.size() > 0) begin
        e = model_q.pop_front();
        mis = (e.pred != ro);
        if (bcnt < CMAX) bcnt++;
        if (mis && mcnt < CMAX) mcnt++;
        ev.uf = 1'b0; ev.pc = e.pc; ev.pred = e.pred; ev.outc = ro;
        ev.mis = mis; ev.bc = bcnt; ev.mc = mcnt;
      end
      exp_q.push_back(ev);
    end
    if (mis || fl) model_q.delete();
    else if (av && ready) model_q.push_back('{pc: apc, pred: ap});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, NOT_TAKEN, 0, NOT_TAKEN, 0);
  endtask

  // Outcome matching the current oldest entry (correct prediction).
  function automatic BranchOutcome head_ok();
    return (model_q.size() > 0) ? model_q[0].pred : NOT_TAKEN;
  endfunction

  function automatic BranchOutcome head_bad();
    return (model_q.size() > 0 && model_q[0].pred == TAKEN) ? NOT_TAKEN : TAKEN;
  endfunction

  // Monitor: consumes expected events whenever the DUT pulses.
  logic [31:0]  last_pc = '0;
  BranchOutcome last_pred = NOT_TAKEN, last_outc = NOT_TAKEN;

  always @(negedge clk) begin
    ev_t ev;
    if (!rst_n) begin
      last_pc = '0; last_pred = NOT_TAKEN; last_outc = NOT_TAKEN;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc_cnt) begin
        ev = exp_q.pop_front();
        chk("missing_event_cycle", 64'(cyc_cnt), 64'(ev.cyc));
      end
      if (o_fb_valid || o_underflow) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {62'd0, o_fb_valid, o_underflow}, 64'd0);
        end else begin
          ev = exp_q.pop_front();
          chk("event_cycle", 64'(cyc_cnt), 64'(ev.cyc));
          chk("underflow", {63'd0, o_underflow}, {63'd0, ev.uf});
          chk("fb_valid", {63'd0, o_fb_valid}, {63'd0, !ev.uf});
          if (!ev.uf) begin
            chk("fb_pc", 64'(o_fb_pc), 64'(ev.pc));
            chk("fb_prediction", 64'(o_fb_prediction), 64'(ev.pred));
            chk("fb_outcome", 64'(o_fb_outcome), 64'(ev.outc));
            chk("mispredict", {63'd0, o_mispredict}, {63'd0, ev.mis});
            chk("branch_count", 64'(o_branch_count), 64'(ev.bc));
            chk("mispredict_count", 64'(o_mispredict_count), 64'(ev.mc));
            last_pc = ev.pc; last_pred = ev.pred; last_outc = ev.outc;
          end else begin
            chk("mispredict_on_underflow", {63'd0, o_mispredict}, 64'd0);
          end
        end
      end else begin
        chk("mispredict_idle", {63'd0, o_mispredict}, 64'd0);
        chk("fb_pc_hold", 64'(o_fb_pc), 64'(last_pc));
        chk("fb_pred_hold", 64'(o_fb_prediction), 64'(last_pred));
        chk("fb_outc_hold", 64'(o_fb_outcome), 64'(last_outc));
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_fb_valid", {63'd0, o_fb_valid}, 64'd0);
    chk("rst_fb_pc", 64'(o_fb_pc), 64'd0);
    chk("rst_fb_prediction", 64'(o_fb_prediction), 64'(NOT_TAKEN));
    chk("rst_fb_outcome", 64'(o_fb_outcome), 64'(NOT_TAKEN));
    chk("rst_mispredict", {63'd0, o_mispredict}, 64'd0);
    chk("rst_underflow", {63'd0, o_underflow}, 64'd0);
    chk("rst_branch_count", 64'(o_branch_count), 64'd0);
    chk("rst_mispredict_count", 64'(o_mispredict_count), 64'd0);
    chk("rst_alloc_ready", {63'd0, o_alloc_ready}, 64'd1);
  endtask

  initial begin
    #3;
    chk_reset_outputs();
    #10 rst_n = 1'b1;

    // Three correctly predicted branches resolved back-to-back.
    step(1, 32'h100, TAKEN, 0, NOT_TAKEN, 0);
    step(1, 32'h104, NOT_TAKEN, 0, NOT_TAKEN, 0);
    step(1, 32'h108, TAKEN, 0, NOT_TAKEN, 0);
    step(0, '0, NOT_TAKEN, 1, TAKEN, 0);
    step(0, '0, NOT_TAKEN, 1, NOT_TAKEN, 0);
    step(0, '0, NOT_TAKEN, 1, TAKEN, 0);
    idle(2);
    chk("dir_branch_count", 64'(o_branch_count), 64'd3);
    chk("dir_mispredict_count", 64'(o_mispredict_count), 64'd0);

    // Fill, drop a 9th alloc, then resolve+alloc while full.
    for (int i = 0; i < QD; i++) step(1, 32'h1000 + 32'(4*i), TAKEN, 0, NOT_TAKEN, 0);
    step(1, 32'hdead, TAKEN, 0, NOT_TAKEN, 0);
    step(1, 32'hbeef, TAKEN, 1, head_ok(), 0);
    step(0, '0, NOT_TAKEN, 0, NOT_TAKEN, 0);
    while (model_q.size() > 0) step(0, '0, NOT_TAKEN, 1, head_ok(), 0);

    // Mispredict squashes younger entries; next resolve underflows.
    step(1, 32'h200, TAKEN, 0, NOT_TAKEN, 0);
    for (int i = 1; i < 4; i++) step(1, 32'h200 + 32'(4*i), NOT_TAKEN, 0, NOT_TAKEN, 0);
    step(1, 32'h300, TAKEN, 1, NOT_TAKEN, 0);
    step(0, '0, NOT_TAKEN, 1, TAKEN, 0);

    // Flush with a concurrent resolve and allocation.
    step(1, 32'h400, NOT_TAKEN, 0, NOT_TAKEN, 0);
    step(1, 32'h404, TAKEN, 0, NOT_TAKEN, 0);
    step(1, 32'h408, TAKEN, 1, NOT_TAKEN, 1);
    step(0, '0, NOT_TAKEN, 1, TAKEN, 0);

    // Pointer wrap with concurrent alloc/resolve pairs.
    step(1, 32'h500, TAKEN, 0, NOT_TAKEN, 0);
    for (int i = 1; i <= 20; i++)
      step(1, 32'h500 + 32'(4*i), BranchOutcome'(i[0]), 1, head_ok(), 0);
    step(0, '0, NOT_TAKEN, 1, head_ok(), 0);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      bit av, rv, fl;
      BranchOutcome ro;
      av = ($urandom_range(0, 99) < 60);
      rv = ($urandom_range(0, 99) < 50);
      fl = ($urandom_range(0, 99) < 2);
      ro = ($urandom_range(0, 99) < 85) ? head_ok() : BranchOutcome'($urandom_range(0, 1));
      step(av, $urandom, BranchOutcome'($urandom_range(0, 1)), rv, ro, fl);
    end

    // Drive both counters to saturation.
    for (int i = 0; i < CMAX + 20; i++) begin
      step(1, 32'h700 + 32'(i), TAKEN, 0, NOT_TAKEN, 0);
      step(0, '0, NOT_TAKEN, 1, head_bad(), 0);
    end
    idle(2);
    chk("sat_branch_count", 64'(o_branch_count), 64'(CMAX));
    chk("sat_mispredict_count", 64'(o_mispredict_count), 64'(CMAX));

    // Asynchronous reset with a feedback pulse in flight.
    step(1, 32'h800, TAKEN, 0, NOT_TAKEN, 0);
    step(1, 32'h804, TAKEN, 1, TAKEN, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    model_q.delete(); exp_q.delete(); bcnt = 0; mcnt = 0;
    i_alloc_valid = 0; i_res_valid = 0; i_flush = 0;
    @(negedge clk);
    chk_reset_outputs();
    #2 rst_n = 1'b1;
    step(0, '0, NOT_TAKEN, 1, TAKEN, 0);
    idle(3);
    chk("post_rst_branch_count", 64'(o_branch_count), 64'd0);
    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
